// File: rtl/apb3_servo_pkg.sv
// Register map, bit positions and helpers shared by the servo bank and its channels.
package apb3_servo_pkg;

  // Register byte offsets
  localparam logic [7:0] CTRL_OFF     = 8'h00;
  localparam logic [7:0] STATUS_OFF   = 8'h04;
  localparam logic [7:0] SLEW_OFF     = 8'h08;
  localparam logic [7:0] TARGET_BASE  = 8'h10;
  localparam logic [7:0] CURRENT_BASE = 8'h30;

  // Address window reserved per per-channel bank (8 channels x 4 bytes)
  localparam int unsigned BANK_BYTES = 32;

  // CTRL / STATUS bit indices
  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
  localparam int unsigned STATUS_DONE_BIT   = 0;
  localparam int unsigned STATUS_MOVING_LSB = 8;

  // Saturate a pulse width into [lo, hi]
  function automatic logic [15:0] clamp_us(input logic [15:0] val, input logic [15:0] lo,
                                           input logic [15:0] hi);
    if (val < lo) begin
      return lo;
    end else if (val > hi) begin
      return hi;
    end
    return val;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: clamped target, once-per-frame slew-limited current width, PWM compare.
module servo_channel
  import apb3_servo_pkg::*;
#(
  parameter int unsigned MIN_US = 500,
  parameter int unsigned MAX_US = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fcnt,
  input  logic        frame_start,
  input  logic        en,
  input  logic [15:0] slew,
  input  logic        wr_target,
  input  logic [15:0] wdata,
  output logic [15:0] target,
  output logic [15:0] current,
  output logic        servo_out
);

  localparam logic [15:0] MinUs = 16'(MIN_US);
  localparam logic [15:0] MaxUs = 16'(MAX_US);

  logic [15:0]        target_q;
  logic [15:0]        current_q;
  logic [15:0]        current_d;
  logic               servo_q;
  logic signed [16:0] diff;
  logic signed [16:0] mag;

  // Slew step toward the target, only at the frame boundary so pulses never glitch
  always_comb begin
    diff      = $signed({1'b0, target_q}) - $signed({1'b0, current_q});
    mag       = diff[16] ? -diff : diff;
    current_d = current_q;
    if (frame_start) begin
      if ((slew == 16'd0) || (mag <= $signed({1'b0, slew}))) begin
        current_d = target_q;
      end else if (diff[16]) begin
        current_d = current_q - slew;
      end else begin
        current_d = current_q + slew;
      end
    end
  end

  // Target/current state and the registered PWM output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q  <= MinUs;
      current_q <= MinUs;
      servo_q   <= 1'b0;
    end else begin
      if (wr_target) begin
        target_q <= clamp_us(wdata, MinUs, MaxUs);
      end
      current_q <= current_d;
      servo_q   <= en && (fcnt < current_q);
    end
  end

  assign target    = target_q;
  assign current   = current_q;
  assign servo_out = servo_q;

endmodule

// File: rtl/apb3_servo_bank.sv
// APB3 bank of NCH servo PWM channels: bus decode, control/status, prescaler and frame counter.
module apb3_servo_bank
  import apb3_servo_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned PRESCALE  = 100,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned MIN_US    = 500,
  parameter int unsigned MAX_US    = 2500
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [7:0]     PADDR,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  output logic [NCH-1:0] SERVO_OUT,
  output logic           FABINT
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic           en_q, irq_en_q, done_q;
  logic [15:0]    slew_q;
  logic [PsW-1:0] pcnt_q;
  logic [15:0]    fcnt_q;
  logic           tick, frame_start;

  logic           aligned, is_ctrl, is_status, is_slew, in_tgt, in_cur, tgt_ok, cur_ok;
  logic           addr_err, wr;
  logic [7:0]     tgt_off, cur_off;
  logic [2:0]     tgt_idx, cur_idx;

  logic [15:0]    target  [NCH];
  logic [15:0]    current [NCH];
  logic [NCH-1:0] moving;
  logic [NCH-1:0] wr_target;
  logic           unused_bits;

  // Address decode and error classification
  always_comb begin
    aligned   = (PADDR[1:0] == 2'b00);
    tgt_off   = PADDR - TARGET_BASE;
    cur_off   = PADDR - CURRENT_BASE;
    tgt_idx   = tgt_off[4:2];
    cur_idx   = cur_off[4:2];
    is_ctrl   = (PADDR == CTRL_OFF);
    is_status = (PADDR == STATUS_OFF);
    is_slew   = (PADDR == SLEW_OFF);
    in_tgt    = aligned && (PADDR >= TARGET_BASE) && (PADDR < CURRENT_BASE);
    in_cur    = aligned && (PADDR >= CURRENT_BASE) &&
                ({24'd0, PADDR} < ({24'd0, CURRENT_BASE} + BANK_BYTES));
    tgt_ok    = in_tgt && ({29'd0, tgt_idx} < NCH);
    cur_ok    = in_cur && ({29'd0, cur_idx} < NCH);
    // CURRENT is read-only, so a write there is an error like an unmapped hole
    addr_err  = !(is_ctrl || is_status || is_slew || tgt_ok || cur_ok) || (PWRITE && cur_ok);
    wr        = PSEL && PENABLE && PWRITE && !addr_err;
  end

  assign unused_bits = ^{tgt_off[7:5], tgt_off[1:0], cur_off[7:5], cur_off[1:0], PWDATA[31:16]};

  // CTRL, SLEW and the sticky FRAME_DONE flag (frame set beats a same-cycle W1C)
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      slew_q   <= 16'd0;
      done_q   <= 1'b0;
    end else begin
      if (wr && is_ctrl) begin
        en_q     <= PWDATA[CTRL_EN_BIT];
        irq_en_q <= PWDATA[CTRL_IRQ_EN_BIT];
      end
      if (wr && is_slew) begin
        slew_q <= PWDATA[15:0];
      end
      if (frame_start) begin
        done_q <= 1'b1;
      end else if (wr && is_status && PWDATA[STATUS_DONE_BIT]) begin
        done_q <= 1'b0;
      end
    end
  end

  assign tick        = en_q && (pcnt_q == PsW'(PRESCALE - 1));
  assign frame_start = tick && (fcnt_q == 16'(PERIOD_US - 1));

  // Microsecond prescaler and frame counter, parked at zero while disabled
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pcnt_q <= '0;
      fcnt_q <= 16'd0;
    end else if (!en_q) begin
      pcnt_q <= '0;
      fcnt_q <= 16'd0;
    end else begin
      pcnt_q <= tick ? '0 : pcnt_q + PsW'(1);
      if (tick) begin
        fcnt_q <= frame_start ? 16'd0 : fcnt_q + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_target[i] = wr && tgt_ok && (tgt_idx == 3'(i));
    assign moving[i]    = (target[i] != current[i]);

    servo_channel #(
      .MIN_US(MIN_US),
      .MAX_US(MAX_US)
    ) u_ch (
      .clk        (PCLK),
      .rst        (PRESET),
      .fcnt       (fcnt_q),
      .frame_start(frame_start),
      .en         (en_q),
      .slew       (slew_q),
      .wr_target  (wr_target[i]),
      .wdata      (PWDATA[15:0]),
      .target     (target[i]),
      .current    (current[i]),
      .servo_out  (SERVO_OUT[i])
    );
  end

  // Combinational read mux, valid from the setup phase
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      if (is_ctrl) begin
        PRDATA[CTRL_EN_BIT]     = en_q;
        PRDATA[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      if (is_status) begin
        PRDATA[STATUS_DONE_BIT]             = done_q;
        PRDATA[STATUS_MOVING_LSB +: NCH]    = moving;
      end
      if (is_slew) begin
        PRDATA[15:0] = slew_q;
      end
      for (int i = 0; i < NCH; i++) begin
        if (tgt_ok && (tgt_idx == 3'(i))) begin
          PRDATA[15:0] = target[i];
        end
        if (cur_ok && (cur_idx == 3'(i))) begin
          PRDATA[15:0] = current[i];
        end
      end
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL && PENABLE && addr_err;
  assign FABINT  = done_q && irq_en_q;

endmodule

// File: doc/apb3_servo_bank.md
# apb3_servo_bank

APB3-attached bank of `NCH` independent hobby-servo PWM channels. It replaces the single fixed servo peripheral in the fabric APB slave. Features: per-channel pulse-width targets, range clamping, slew-rate limiting applied once per frame, and a frame-done interrupt on `FABINT`. It sits on the fabric APB3 bus beside the neopixel and NFC peripherals and drives `SERVO_OUT` pins directly.

## Interface
Parameters:
- `NCH`, 4: number of servo channels (1..8).
- `PRESCALE`, 100: PCLK cycles per 1 µs tick (≥2).
- `PERIOD_US`, 20000: frame length in µs (≤65535).
- `MIN_US`, 500: lower clamp for pulse width.
- `MAX_US`, 2500: upper clamp for pulse width (< `PERIOD_US`).

Ports:
- `PCLK` in 1: bus and fabric clock.
- `PRESET` in 1: asynchronous, active-high reset.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write.
- `PADDR` in 8: byte address.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied 1.
- `PSLVERR` out 1: error response.
- `SERVO_OUT` out `NCH`: PWM outputs.
- `FABINT` out 1: level interrupt.

## Operation
Register map (word-aligned):
- 0x00 CTRL (RW): bit0 `EN`, bit1 `IRQ_EN`. Reset value 0.
- 0x04 STATUS: bit0 `FRAME_DONE`, sticky, write-1-to-clear. Bits[8+NCH-1:8] `MOVING[i]` (RO) = current≠target.
- 0x08 SLEW (RW, 16 b): maximum µs change per frame. 0 = jump directly to target.
- 0x10+4i TARGET[i] (RW, 16 b): written value is clamped to [`MIN_US`,`MAX_US`]. Readback returns the clamped value. Reset value `MIN_US`.
- 0x30+4i CURRENT[i] (RO, 16 b): pulse width actually output. Reset value `MIN_US`.

Bus rules:
- `PSLVERR`=1 during the access phase for any of: unmapped address, channel index ≥`NCH`, write to 0x30+ range. Erroring writes have no effect.
- Unused `PRDATA` bits read 0.

Timebase:
- Prescaler counts 0..`PRESCALE`-1 and emits a 1-cycle `tick` at the top.
- Frame counter `fcnt` (16 b) increments on `tick`, wrapping `PERIOD_US`-1 → 0.
- The wrap cycle is `frame_start`. It sets `FRAME_DONE` and updates every CURRENT[i]:
  - `d = target − current`
  - if SLEW=0 or |d| ≤ SLEW: `current = target`
  - otherwise `current += sign(d)·SLEW`
- Use 17-bit signed difference arithmetic; no overflow is possible given the clamp.
- `SERVO_OUT[i]` = registered (`EN` && `fcnt` < CURRENT[i]).
- `FABINT` = `FRAME_DONE` && `IRQ_EN`.

Enable:
- `EN`=0: prescaler and `fcnt` are held at 0, outputs are low, no `frame_start`. TARGET and CURRENT remain writable/retained.
- `EN` rising: counting starts from 0 on the next cycle. The first frame uses the existing CURRENT values, with no slew step.

## Timing
- Writes commit on the PCLK edge where `PSEL`&`PENABLE`&`PWRITE`.
- `PRDATA` is combinational from `PADDR` whenever `PSEL`&!`PWRITE`, valid from the setup phase.
- TARGET written mid-frame takes effect at the next `frame_start`. CURRENT never changes mid-frame, so there are no glitched pulses.
- `SERVO_OUT` rises one cycle after the `frame_start` cycle.
- Pulse high time is exactly CURRENT·`PRESCALE` cycles.
- Simultaneous W1C and `frame_start`: set wins, `FRAME_DONE` stays 1.
- Simultaneous TARGET write and `frame_start`: the slew step uses the old target; the new target is stored.
- Reset asserted mid-frame: all registers return to reset values immediately; `SERVO_OUT`=0 and `FABINT`=0 asynchronously.

## Structure
- Package `apb3_servo_pkg`: register offsets (CTRL, STATUS, SLEW, TARGET_BASE, CURRENT_BASE) and CTRL/STATUS bit indices.
- Sub-module `servo_channel`, instantiated `NCH` times:
  - holds TARGET/CURRENT, the clamp, the slew step and the output comparator;
  - inputs: `fcnt`, `frame_start`, `EN`, SLEW, write strobe/data.
- The top level holds the APB decode, CTRL/STATUS/SLEW, the prescaler and the frame counter.

## Test plan
- Reset then read all registers → CTRL=0, STATUS=0, SLEW=0, TARGET/CURRENT=500. `SERVO_OUT`=0, `FABINT`=0.
- `PRESCALE`=4, `PERIOD_US`=100, MIN=5, MAX=80. TARGET0=20, EN=1 → each frame is 400 cycles; ch0 high for 80 cycles after the first frame boundary.
- Write TARGET1=3 and TARGET2=1000 → readback 5 and 80; 0x30 write and 0x7C read → `PSLVERR`=1, with no state change.
- SLEW=10, CURRENT0=20, TARGET0=55 → CURRENT0 goes 30, 40, 50, 55 across successive frames; `MOVING[0]` clears on the 55 frame.
- IRQ_EN=1 → `FABINT` rises at `frame_start`. A W1C on the same cycle as the next `frame_start` leaves `FRAME_DONE`=1; a W1C on another cycle clears it.
- Assert `PRESET` mid-pulse → outputs drop immediately, and all values return to reset values.
